// File: rtl/blink_scheduler.sv
// -----------------------------------------------------------------------------
// blink_scheduler
//
// Command-driven LED sequencer. A remote command source loads up to four
// {pattern, duration} slots, then starts, stops or overrides playback. While
// running, slots 0..last_slot are played in a loop. Each slot lasts
// eff_dur * TICK_DIV clock cycles, where eff_dur = duration (0 counts as 1).
//
// Parameters
//   CLK_FREQ  board clock in Hz, only used to derive the TICK_DIV default
//   TICK_DIV  clk cycles per duration tick (>= 2)
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command can be accepted this cycle (low for one cycle after
//              each acceptance)
//   cmd_op     0=WRITE 1=START 2=STOP 3=FORCE
//   cmd_slot   target slot for WRITE
//   cmd_data   WRITE: [23:16] pattern, [15:0] duration in ticks
//              START: [1:0] last slot;  FORCE: [7:0] pattern
//   leds       registered LED drive
//   busy       high while playing
//   cur_slot   slot currently playing (holds its value when stopped)
//   slot_done  one-cycle pulse when a slot expires and playback advances
// -----------------------------------------------------------------------------
module blink_scheduler #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned TICK_DIV = CLK_FREQ / 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_slot,
  input  logic [23:0] cmd_data,
  output logic [7:0]  leds,
  output logic        busy,
  output logic [1:0]  cur_slot,
  output logic        slot_done
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_FORCE = 2'd3
  } op_t;

  state_t         state;
  logic [7:0]     slot_pat [4];
  logic [15:0]    slot_dur [4];
  logic [1:0]     last_slot;
  logic [PW-1:0]  presc;
  logic [15:0]    tick_cnt;

  op_t            op;
  logic           accept;
  logic           tick;
  logic           expire;
  logic [15:0]    eff_dur;
  logic [1:0]     next_slot;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    op        = op_t'(cmd_op);
    accept    = cmd_valid && cmd_ready;
    tick      = (state == RUN) && (presc == PRESC_MAX);
    eff_dur   = (slot_dur[cur_slot] == 16'd0) ? 16'd1 : slot_dur[cur_slot];
    // 17-bit compare so tick_cnt+1 cannot wrap at 65535.
    expire    = tick && (({1'b0, tick_cnt} + 17'd1) >= {1'b0, eff_dur});
    next_slot = (cur_slot == last_slot) ? 2'd0 : cur_slot + 2'd1;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in the block override
  // earlier ones, which is how commands take priority over playback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      leds      <= 8'h00;
      busy      <= 1'b0;
      cur_slot  <= 2'd0;
      slot_done <= 1'b0;
      cmd_ready <= 1'b1;
      last_slot <= 2'd0;
      presc     <= '0;
      tick_cnt  <= 16'd0;
      // NOTE: the slot table is reset explicitly so a START straight after
      // reset plays a known blank pattern; a plain RAM would not be reset.
      for (int i = 0; i < 4; i++) begin
        slot_pat[i] <= 8'h00;
        slot_dur[i] <= 16'd0;
      end
    end else begin
      // One dead cycle after every acceptance.
      cmd_ready <= !accept;
      slot_done <= 1'b0;

      if (state == RUN) begin
        // Refreshed every cycle so a WRITE to the playing slot shows up
        // on the edge after it is stored.
        leds <= slot_pat[cur_slot];
        if (expire) begin
          slot_done <= 1'b1;
          cur_slot  <= next_slot;
          presc     <= '0;
          tick_cnt  <= 16'd0;
          leds      <= slot_pat[next_slot];
        end else if (tick) begin
          presc    <= '0;
          tick_cnt <= tick_cnt + 16'd1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      if (accept) begin
        // A command on an expiry edge hides that expiry's pulse.
        slot_done <= 1'b0;
        unique case (op)
          OP_WRITE: begin
            slot_pat[cmd_slot] <= cmd_data[23:16];
            slot_dur[cmd_slot] <= cmd_data[15:0];
          end
          OP_START: begin
            state     <= RUN;
            busy      <= 1'b1;
            last_slot <= cmd_data[1:0];
            cur_slot  <= 2'd0;
            presc     <= '0;
            tick_cnt  <= 16'd0;
            leds      <= slot_pat[0];
          end
          OP_STOP: begin
            state    <= IDLE;
            busy     <= 1'b0;
            presc    <= '0;
            tick_cnt <= 16'd0;
            leds     <= 8'h00;
          end
          OP_FORCE: begin
            state    <= IDLE;
            busy     <= 1'b0;
            presc    <= '0;
            tick_cnt <= 16'd0;
            leds     <= cmd_data[7:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// -----------------------------------------------------------------------------
// tb_blink_scheduler
//
// Self-checking bench for blink_scheduler with TICK_DIV=4. Each scenario
// pushes the expected per-cycle output into a queue as it drives commands,
// then pops and compares one entry per clock on the falling edge.
// -----------------------------------------------------------------------------
module tb_blink_scheduler;

  localparam int unsigned TICK_DIV = 4;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_FORCE = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_slot;
  logic [23:0] cmd_data;
  logic [7:0]  leds;
  logic        busy;
  logic [1:0]  cur_slot;
  logic        slot_done;

  typedef struct packed {
    logic [7:0] leds;
    logic [1:0] cur;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  blink_scheduler #(
    .CLK_FREQ (4000),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_slot  (cmd_slot),
    .cmd_data  (cmd_data),
    .leds      (leds),
    .busy      (busy),
    .cur_slot  (cur_slot),
    .slot_done (slot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for cmd_ready on a falling edge, presents the command for one
  // rising edge (the accept edge) and returns 1 time unit after it.
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] slot,
                          input logic [23:0] data);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_ready_timeout got=%0b want=1", cmd_ready);
    end
    cmd_op    = op;
    cmd_slot  = slot;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] l, input logic [1:0] c,
                      input logic b, input logic d);
    exp_t e;
    e.leds = l;
    e.cur  = c;
    e.busy = b;
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_slot  = 2'd0;
    cmd_data  = 24'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({leds, busy, cur_slot, slot_done, cmd_ready} !== {8'h00, 1'b0, 2'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values got leds=%h busy=%b cur=%0d done=%b rdy=%b want 00 0 0 0 1",
               leds, busy, cur_slot, slot_done, cmd_ready);
    end
    send_cmd(OP_WRITE, 2'd0, {8'h55, 16'd2});
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_low_after_accept got=%b want=0", cmd_ready);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_back_high got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_playback();
    exp_t e;
    int   ph;
    send_cmd(OP_WRITE, 2'd1, {8'hE0, 16'd1});
    send_cmd(OP_START, 2'd0, 24'd1);
    // Slot 0 lasts 2*4=8 cycles, slot 1 lasts 1*4=4 cycles.
    for (int i = 0; i < 20; i++) begin
      ph = i % 12;
      if (ph < 8) push(8'h55, 2'd0, 1'b1, (i > 0) && (ph == 0));
      else        push(8'hE0, 2'd1, 1'b1, ph == 8);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({leds, cur_slot, busy, slot_done} !== e) begin
        bad++;
        $display("FAIL playback[%0d] got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
                 i, leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
      end
    end
  endtask

  task automatic test_stop_force();
    exp_t e;
    // Playback ends sampled after edge 19; STOP lands on edge 21, in slot 1.
    send_cmd(OP_STOP, 2'd0, 24'd0);
    push(8'h00, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if ({leds, cur_slot, busy, slot_done} !== e) begin
      bad++;
      $display("FAIL stop got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
               leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
    end
    send_cmd(OP_FORCE, 2'd0, 24'h00007F);
    for (int i = 0; i < 50; i++) push(8'h7F, 2'd1, 1'b0, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({leds, cur_slot, busy, slot_done} !== e) begin
        bad++;
        $display("FAIL force[%0d] got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
                 i, leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
      end
    end
  endtask

  task automatic test_zero_duration();
    exp_t e;
    send_cmd(OP_WRITE, 2'd0, {8'h3C, 16'd0});
    send_cmd(OP_START, 2'd0, 24'd0);
    for (int i = 0; i < 17; i++) push(8'h3C, 2'd0, 1'b1, (i > 0) && (i % 4 == 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({leds, cur_slot, busy, slot_done} !== e) begin
        bad++;
        $display("FAIL zero_dur[%0d] got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
                 i, leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
      end
    end
  endtask

  task automatic test_live_write();
    exp_t e;
    send_cmd(OP_WRITE, 2'd0, {8'h11, 16'd1});
    send_cmd(OP_WRITE, 2'd1, {8'h22, 16'd5});
    send_cmd(OP_START, 2'd0, 24'd1);
    // Slot 0 expires at edge 4; slot 1 ticks at 8, 12, 16 -> count 3.
    repeat (16) @(posedge clk);
    #1;
    total++;
    if ({leds, cur_slot, slot_done} !== {8'h22, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL live_pre got leds=%h cur=%0d done=%b want leds=22 cur=1 done=0",
               leds, cur_slot, slot_done);
    end
    // Accepted on edge 17: duration 2 is already exceeded, so edge 20 expires.
    send_cmd(OP_WRITE, 2'd1, {8'hAA, 16'd2});
    push(8'h22, 2'd1, 1'b1, 1'b0);
    push(8'hAA, 2'd1, 1'b1, 1'b0);
    push(8'hAA, 2'd1, 1'b1, 1'b0);
    push(8'h11, 2'd0, 1'b1, 1'b1);
    push(8'h11, 2'd0, 1'b1, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({leds, cur_slot, busy, slot_done} !== e) begin
        bad++;
        $display("FAIL live_write[%0d] got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
                 i, leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
      end
    end
  endtask

  task automatic test_start_on_expiry();
    exp_t e;
    send_cmd(OP_WRITE, 2'd1, {8'h22, 16'd1});
    send_cmd(OP_START, 2'd0, 24'd1);
    // Slot 0 (1 tick) would expire on edge 4; START lands on that edge.
    repeat (3) @(posedge clk);
    #1;
    send_cmd(OP_START, 2'd0, 24'd1);
    for (int i = 0; i < 4; i++) push(8'h11, 2'd0, 1'b1, 1'b0);
    push(8'h22, 2'd1, 1'b1, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({leds, cur_slot, busy, slot_done} !== e) begin
        bad++;
        $display("FAIL start_on_expiry[%0d] got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
                 i, leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({leds, busy, cur_slot, slot_done, cmd_ready} !== {8'h00, 1'b0, 2'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid_run got leds=%h busy=%b cur=%0d done=%b rdy=%b want 00 0 0 0 1",
               leds, busy, cur_slot, slot_done, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Slots were cleared: slot 0 is {00, 0} and expires every tick.
    send_cmd(OP_START, 2'd0, 24'd0);
    for (int i = 0; i < 4; i++) push(8'h00, 2'd0, 1'b1, 1'b0);
    push(8'h00, 2'd0, 1'b1, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({leds, cur_slot, busy, slot_done} !== e) begin
        bad++;
        $display("FAIL after_reset[%0d] got leds=%h cur=%0d busy=%b done=%b want leds=%h cur=%0d busy=%b done=%b",
                 i, leds, cur_slot, busy, slot_done, e.leds, e.cur, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_stop_force();
    test_zero_duration();
    test_live_write();
    test_start_on_expiry();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
